// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait holds, plus timeout and stall accounting.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, LOAD_USE, BR_SHADOW, MEM_WAIT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_q, stall_d;
  logic        hz;
  logic        mem_wait;

  // XZR is never a real producer, so it cannot create a load-use dependency.
  assign hz = ex_memread && (ex_rd != 5'd31) &&
              ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_hold     = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        MEM_WAIT: begin
          if (!mem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_d == 8'hFF) mem_timeout_d = 1'b1;
          end else begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
          end
        end
        default: begin
          // Detection is only armed in RUN; after a bubble or flush the
          // offending instruction is no longer paired with the load in EX.
          state_d = RUN;
          if (mem_wait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_d    = MEM_WAIT;
          end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = BR_SHADOW;
          end else if (hz && (state_q == RUN)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LOAD_USE;
          end
        end
      endcase
    end
    stall_d = stall_q;
    if (!pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a rule-level model checked every cycle,
// plus hand-computed literal checks at the key points of each scenario.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rn = '0, id_rm = '0, ex_rd = '0;
  logic        id_uses_rn = 1'b0, id_uses_rm = 1'b0;
  logic        ex_memread = 1'b0, br_taken = 1'b0;
  logic        mem_req = 1'b0, mem_ready = 1'b0;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
  logic        pipe_hold, mem_timeout;
  logic [15:0] stall_cycles;

  int assertCount = 0;
  int failCount = 0;

  // Model state: whether the pipe is waiting on memory, whether detection
  // is masked for this cycle, and plain integer counters.
  bit modelValid = 1'b0;
  bit waiting = 1'b0;
  bit suppress = 1'b0;
  bit timeout = 1'b0;
  int waitCount = 0;
  int stallCount = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; literal checks follow 3 units later.
  task automatic applyStimulus(input bit rst, input bit mReq, input bit mRdy, input bit brT,
                               input bit exLd, input logic [4:0] exRd,
                               input logic [4:0] rn, input bit useRn,
                               input logic [4:0] rm, input bit useRm);
    @(posedge clk);
    #1;
    reset = rst; mem_req = mReq; mem_ready = mRdy; br_taken = brT;
    ex_memread = exLd; ex_rd = exRd; id_rn = rn; id_uses_rn = useRn;
    id_rm = rm; id_uses_rm = useRm;
    #3;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  always @(negedge clk) begin
    bit hzM;
    bit ePc, eIfw, eBub, eIff, eIdf, eHold;
    hzM = ex_memread && (ex_rd != 5'd31) &&
          ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
    if (modelValid) begin
      checkOutput("stall_cycles", stall_cycles, 16'(stallCount));
      checkOutput("mem_timeout", {15'd0, mem_timeout}, {15'd0, timeout});
    end
    ePc = 1; eIfw = 1; eBub = 0; eIff = 0; eIdf = 0; eHold = 0;
    if (reset) begin
      ePc = 0; eIfw = 0; eIff = 1; eIdf = 1; eBub = 1;
      waiting = 0; suppress = 0; timeout = 0; waitCount = 0; stallCount = 0;
      modelValid = 1;
    end else begin
      if (waiting) begin
        if (!mem_ready) begin
          ePc = 0; eIfw = 0; eHold = 1;
          if (waitCount < 255) waitCount++;
          if (waitCount == 255) timeout = 1;
        end else begin
          waiting = 0; waitCount = 0;
        end
        suppress = 0;
      end else if (mem_req && !mem_ready) begin
        ePc = 0; eIfw = 0; eHold = 1; waiting = 1; suppress = 0;
      end else if (br_taken) begin
        eIff = 1; eIdf = 1; suppress = 1;
      end else if (hzM && !suppress) begin
        ePc = 0; eIfw = 0; eBub = 1; suppress = 1;
      end else begin
        suppress = 0;
      end
      if (!ePc && stallCount < 65535) stallCount++;
    end
    checkOutput("pc_write", {15'd0, pc_write}, {15'd0, ePc});
    checkOutput("ifid_write", {15'd0, ifid_write}, {15'd0, eIfw});
    checkOutput("idex_bubble", {15'd0, idex_bubble}, {15'd0, eBub});
    checkOutput("ifid_flush", {15'd0, ifid_flush}, {15'd0, eIff});
    checkOutput("idex_flush", {15'd0, idex_flush}, {15'd0, eIdf});
    checkOutput("pipe_hold", {15'd0, pipe_hold}, {15'd0, eHold});
  end

  initial begin
    // Reset: flush/bubble outputs regardless of other inputs
    applyStimulus(1, 1, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    checkOutput("rst_pc_write", {15'd0, pc_write}, 16'd0);
    checkOutput("rst_pipe_hold", {15'd0, pipe_hold}, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    checkOutput("rst_idex_bubble", {15'd0, idex_bubble}, 16'd1);
    checkOutput("rst_stall", stall_cycles, 16'd0);
    idle();
    checkOutput("post_rst_pc_write", {15'd0, pc_write}, 16'd1);

    // Load-use with rn, held hazard masked once, then re-detected
    applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    checkOutput("lu_bubble", {15'd0, idex_bubble}, 16'd1);
    checkOutput("lu_pc_write", {15'd0, pc_write}, 16'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    checkOutput("lu_next_pc_write", {15'd0, pc_write}, 16'd1);
    checkOutput("lu_stall", stall_cycles, 16'd1);
    applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    checkOutput("lu_again_bubble", {15'd0, idex_bubble}, 16'd1);
    idle();
    checkOutput("lu_stall2", stall_cycles, 16'd2);

    // XZR never stalls; rm path and unused-operand path
    applyStimulus(0, 0, 0, 0, 1, 5'd31, 5'd31, 1, 5'd31, 1);
    checkOutput("xzr_pc_write", {15'd0, pc_write}, 16'd1);
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 1);
    checkOutput("rm_bubble", {15'd0, idex_bubble}, 16'd1);
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd3, 1);
    applyStimulus(0, 0, 0, 0, 0, 5'd7, 5'd7, 1, 5'd7, 1);
    idle();

    // Branch beats hazard, shadow masks the next hazard
    applyStimulus(0, 0, 0, 1, 1, 5'd9, 5'd9, 1, 5'd0, 0);
    checkOutput("br_ifid_flush", {15'd0, ifid_flush}, 16'd1);
    checkOutput("br_bubble", {15'd0, idex_bubble}, 16'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
    checkOutput("shadow_pc_write", {15'd0, pc_write}, 16'd1);
    applyStimulus(0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
    applyStimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    applyStimulus(0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    applyStimulus(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle();

    // Memory wait for 3 cycles, branch and hazard ignored while waiting
    applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    checkOutput("mw_hold", {15'd0, pipe_hold}, 16'd1);
    applyStimulus(0, 1, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0);
    checkOutput("mw_no_flush", {15'd0, ifid_flush}, 16'd0);
    applyStimulus(0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    checkOutput("mw_pc_write", {15'd0, pc_write}, 16'd0);
    applyStimulus(0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    checkOutput("mw_done_hold", {15'd0, pipe_hold}, 16'd0);
    checkOutput("mw_done_flush", {15'd0, ifid_flush}, 16'd0);
    idle();

    // Timeout after 255 waiting cycles, sticky until reset
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
      if (i == 255) checkOutput("to_before", {15'd0, mem_timeout}, 16'd0);
      if (i == 256) checkOutput("to_set", {15'd0, mem_timeout}, 16'd1);
    end
    checkOutput("to_sticky", {15'd0, mem_timeout}, 16'd1);
    applyStimulus(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle();
    checkOutput("to_after_exit", {15'd0, mem_timeout}, 16'd1);
    applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    applyStimulus(1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    checkOutput("rst_mid_flush", {15'd0, idex_flush}, 16'd1);
    checkOutput("rst_mid_hold", {15'd0, pipe_hold}, 16'd0);
    idle();
    checkOutput("rst_mid_timeout", {15'd0, mem_timeout}, 16'd0);
    checkOutput("rst_mid_stall", stall_cycles, 16'd0);
    checkOutput("rst_mid_pc_write", {15'd0, pc_write}, 16'd1);

    // Hazard right out of reset is detected in RUN
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd2, 5'd0, 0, 5'd2, 1);
    checkOutput("rst_lu_bubble", {15'd0, idex_bubble}, 16'd1);
    idle();
    idle();

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
